ahb_resp_mux: RTL and testbench

Slave-to-master return path of the AHB interconnect. The address decoder drives HSELx in the address phase. This block registers that select into the data phase and multiplexes HRDATA/HREADYOUT/HRESP from NUM_SLAVES slaves back to the master. It also contains a built-in default slave that answers unmapped transfers with the two-cycle AHB ERROR response.

---
 rtl/ahb_pkg.sv | 10 +
 rtl/ahb_default_slave.sv | 23 ++
 rtl/ahb_resp_mux.sv | 47 ++++
 tb/tb_ahb_resp_mux.sv | 93 +++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB transfer/response encodings and the default-slave state type
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [1:0] {DS_OKAY, DS_ERR1, DS_ERR2} ds_state_e;
endpackage

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: two-cycle ERROR responder for unmapped NONSEQ/SEQ; in HCLK,HRESETn,sel,HTRANS,HREADY; out readyout,resp
import ahb_pkg::*;
module ahb_default_slave (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       sel,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       readyout,
  output logic       resp
);
  ds_state_e state, state_d;
  logic err_req;
  assign err_req = HREADY && sel && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) state <= DS_OKAY;
    else state <= state_d;
  always_comb begin
    state_d  = state == DS_ERR1 ? DS_ERR2 : err_req ? DS_ERR1 : DS_OKAY;
    readyout = state != DS_ERR1;
    resp     = state == DS_OKAY ? HRESP_OKAY : HRESP_ERROR;
  end
endmodule

// File: rtl/ahb_resp_mux.sv
// ahb_resp_mux: data-phase slave select + HRDATA/HREADY/HRESP return mux with default slave (ERROR response under AHB_DEFAULT_SLAVE_ERR_EN); in HCLK,HRESETn,HSELx,HTRANS,HRDATA_S,HREADYOUT_S,HRESP_S; out HRDATA,HREADY,HRESP
import ahb_pkg::*;
module ahb_resp_mux #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W     = 32
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [NUM_SLAVES-1:0]        HSELx,
  input  logic [1:0]                   HTRANS,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]        HRESP_S,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADY,
  output logic                         HRESP
);
  logic [NUM_SLAVES:0] sel_q, sel_d;
  logic ds_ready, ds_resp;
  // x & -x isolates the lowest set bit; the top bit marks the default slave
  assign sel_d = {~|HSELx, HSELx & (-HSELx)};
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) sel_q <= {1'b1, {NUM_SLAVES{1'b0}}};
    else if (HREADY) sel_q <= sel_d;
`ifdef AHB_DEFAULT_SLAVE_ERR_EN
  ahb_default_slave u_ds (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .sel(~|HSELx),
    .HTRANS(HTRANS),
    .HREADY(HREADY),
    .readyout(ds_ready),
    .resp(ds_resp)
  );
`else
  logic unused_htrans;
  assign unused_htrans = ^HTRANS;
  assign ds_ready = 1'b1;
  assign ds_resp  = HRESP_OKAY;
`endif
  assign HREADY = |({ds_ready, HREADYOUT_S} & sel_q);
  assign HRESP  = |({ds_resp, HRESP_S} & sel_q);
  always_comb begin
    HRDATA = '0;
    for (int i = 0; i < NUM_SLAVES; i++) HRDATA |= sel_q[i] ? HRDATA_S[i*DATA_W +: DATA_W] : '0;
  end
endmodule

// File: tb/tb_ahb_resp_mux.sv
// tb_ahb_resp_mux: directed scoreboard bench for ahb_resp_mux
module tb_ahb_resp_mux;
`ifdef AHB_DEFAULT_SLAVE_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  typedef struct packed {logic rdy; logic rsp; logic [31:0] data;} exp_t;
  logic HCLK = 1'b0, HRESETn = 1'b0;
  logic [3:0] HSELx = '0, HREADYOUT_S = 4'hf, HRESP_S = '0;
  logic [1:0] HTRANS = 2'b00;
  logic [127:0] HRDATA_S = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0A0A_0A0A};
  logic [31:0] HRDATA;
  logic HREADY, HRESP;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, stp = 0;
  ahb_resp_mux dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELx(HSELx), .HTRANS(HTRANS),
    .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );
  always #5 HCLK = ~HCLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s step %0d: got %h expected %h", tag, stp, got, want);
    end
  endtask
  task automatic pop_chk();
    exp_t e;
    if (q.size() == 0) begin
      n_chk++; n_fail++;
      $error("FAIL scoreboard step %0d: got empty queue expected entry", stp);
    end else begin
      e = q.pop_front();
      chk("hready", {31'd0, HREADY}, {31'd0, e.rdy});
      chk("hresp", {31'd0, HRESP}, {31'd0, e.rsp});
      chk("hrdata", HRDATA, e.data);
    end
  endtask
  task automatic step(input logic [3:0] sel, input logic [1:0] tr, input logic [3:0] rdy,
                      input logic [3:0] rsp, input logic er, input logic ep, input logic [31:0] ed);
    stp++;
    HSELx = sel; HTRANS = tr; HREADYOUT_S = rdy; HRESP_S = rsp;
    q.push_back('{er, ep, ed});
    @(negedge HCLK);
    pop_chk();
    @(posedge HCLK);
    #1;
  endtask
  initial begin
    @(posedge HCLK); #1;
    step(4'b0000, 2'b00, 4'hf, 4'h0, 1, 0, 0);
    step(4'b0000, 2'b10, 4'hf, 4'h0, 1, 0, 0);
    HRESETn = 1'b1;
    step(4'b0000, 2'b00, 4'hf, 4'h0, 1, 0, 0);
    step(4'b0000, 2'b00, 4'hf, 4'h0, 1, 0, 0);
    step(4'b0100, 2'b10, 4'hf, 4'h0, 1, 0, 0);
    step(4'b0000, 2'b00, 4'hf, 4'h0, 1, 0, 32'hDEAD_BEEF);
    step(4'b0010, 2'b10, 4'hf, 4'h0, 1, 0, 0);
    step(4'b1000, 2'b10, 4'b1101, 4'h0, 0, 0, 32'h1111_1111);
    step(4'b0000, 2'b10, 4'b1101, 4'h0, 0, 0, 32'h1111_1111);
    step(4'b1000, 2'b10, 4'hf, 4'h0, 1, 0, 32'h1111_1111);
    step(4'b0000, 2'b00, 4'hf, 4'h0, 1, 0, 32'h3333_3333);
    step(4'b0011, 2'b10, 4'hf, 4'h0, 1, 0, 0);
    step(4'b0000, 2'b10, 4'hf, 4'b0001, 1, 1, 32'h0A0A_0A0A);
    step(4'b0000, 2'b00, 4'hf, 4'h0, !ERR, ERR, 0);
    step(4'b0000, 2'b00, 4'hf, 4'h0, 1, ERR, 0);
    step(4'b0000, 2'b11, 4'hf, 4'h0, 1, 0, 0);
    step(4'b0000, 2'b11, 4'hf, 4'h0, !ERR, ERR, 0);
    step(4'b0000, 2'b11, 4'hf, 4'h0, 1, ERR, 0);
    step(4'b0000, 2'b00, 4'hf, 4'h0, !ERR, ERR, 0);
    step(4'b0000, 2'b00, 4'hf, 4'h0, 1, ERR, 0);
    step(4'b0000, 2'b01, 4'hf, 4'h0, 1, 0, 0);
    step(4'b0000, 2'b10, 4'hf, 4'h0, 1, 0, 0);
    stp++;
    HSELx = 4'b0000; HTRANS = 2'b00;
    q.push_back('{!ERR, ERR, 32'd0});
    @(negedge HCLK);
    pop_chk();
    #2 HRESETn = 1'b0;
    q.push_back('{1'b1, 1'b0, 32'd0});
    #1 pop_chk();
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    step(4'b0100, 2'b10, 4'hf, 4'h0, 1, 0, 0);
    step(4'b0000, 2'b00, 4'hf, 4'h0, 1, 0, 32'hDEAD_BEEF);
    step(4'b0000, 2'b00, 4'hf, 4'h0, 1, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
